pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter register and selects next-PC from PC+4, branch, jump and jump-register targets.
- Drives the instruction-memory address and latches the IF/ID pipeline register.
- Sits directly upstream of ID; consumes the same Stall_PC hazard signal used across the pipeline.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble instruction (sll $0,$0,0) inserted on flush.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset; asynchronous, active-low.
- Stall_PC  input  1  hold PC (load-use hazard).
- Stall_IFID  input  1  hold IF/ID register contents.
- Flush_IFID  input  1  replace IF/ID contents with a bubble.
- BranchTaken  input  1  branch resolved taken.
- BranchTarget  input  32  branch target address.
- Jump  input  1  j/jal.
- JumpTarget  input  32  jump target address.
- JumpReg  input  1  jr/jalr.
- JumpRegTarget  input  32  register target address.
- Instruction_In  input  32  instruction-memory read data for PC_Out (combinational read).
- PC_Out  output  32  current PC to instruction memory.
- IFID_Instruction  output  32  latched instruction.
- IFID_PCPlus4  output  32  latched PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction.
- Misaligned  output  1  sticky flag: a redirect target had bits[1:0] != 0.
- FetchCount  output  CNT_W  instructions latched into IF/ID.
- RedirectCount  output  CNT_W  redirects taken.

Behaviour:
- Reset (Rst=0, async):
  - PC_Out=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0.
  - IFID_Valid=0, Misaligned=0, both counters=0, state=BOOT.
- State machine:
  - BOOT: one cycle after Rst deasserts. PC is not updated and IF/ID is not loaded.
  - BOOT always moves to RUN on the next edge.
  - RUN: normal operation; there is no other exit except reset.
- PC+4 is computed internally, 32-bit, wrapping mod 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Next-PC priority in RUN, per edge:
  1. JumpReg -> JumpRegTarget
  2. Jump -> JumpTarget
  3. BranchTaken -> BranchTarget
  4. Stall_PC -> hold
  5. otherwise -> PC+4
- Redirects override Stall_PC (the redirecting instruction is older than the stalled one).
- Selected redirect target is word-aligned by forcing bits[1:0]=00. If the raw target's bits[1:0] != 0, set Misaligned (sticky until reset).
- IF/ID update in RUN, priority:
  1. Flush_IFID -> Instruction=NOP_INSTR, PCPlus4 unchanged, Valid=0.
  2. Stall_IFID -> hold all three fields.
  3. otherwise -> Instruction=Instruction_In, PCPlus4=PC+4, Valid=1.
- A redirect does not flush IF/ID by itself; the hazard unit asserts Flush_IFID in the same cycle.
- FetchCount increments on each RUN edge that takes IF/ID branch (3).
- RedirectCount increments on each RUN edge where any redirect is selected.
- Both counters saturate at all-ones.
- Latency: PC_Out changes one edge after selection. Instruction_In at PC_Out appears on IFID_Instruction one edge later.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of Clk; the BOOT cycle repeats.

Decomposition:
- Shared package pipeline_pkg holds:
  - RESET_PC and NOP_INSTR defaults
  - the BOOT/RUN state encoding
  - a next-PC select enum (SEL_PC4, SEL_BR, SEL_J, SEL_JR, SEL_HOLD)
- One natural sub-module: next_pc_select. It is combinational: priority mux, alignment mask, misalignment detect and select code.
- The PC register, IF/ID register, FSM and counters stay in pc_fetch_stage.

Test Plan:
- Reset then free-run, Instruction_In = PC-derived pattern:
  - PC_Out is 0 during the BOOT cycle, then 0, 4, 8, 12 on successive edges.
  - IFID_PCPlus4 follows 4, 8, 12 one edge behind.
  - FetchCount counts 1, 2, 3.
- Stall_PC=1 and Stall_IFID=1 for 2 cycles at PC=0x10:
  - PC_Out holds 0x10 and the IF/ID fields hold.
  - FetchCount is frozen, then resumes with 0x14.
- Simultaneous JumpReg (target 0x200), Jump (0x100), BranchTaken (0x80) and Stall_PC=1:
  - Next PC_Out = 0x200, RedirectCount +1.
- BranchTaken with BranchTarget=0x00000043:
  - PC_Out = 0x40 and Misaligned=1.
  - Misaligned stays 1 after further clean redirects until Rst=0.
- Flush_IFID=1 together with Stall_IFID=1:
  - IFID_Instruction = 0x00000000 and IFID_Valid=0.
  - FetchCount is unchanged.
- PC at 0xFFFFFFFC with no redirect: PC_Out wraps to 0x00000000. Separately, with CNT_W=4, force 20 fetches: FetchCount saturates at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline front end: fetch FSM encoding,
// next-PC select codes and reset constants.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } fetch_state_e;

  typedef enum logic [2:0] {
    SEL_PC4,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_HOLD
  } npc_sel_e;

  function automatic logic is_redirect(input npc_sel_e sel);
    return (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR);
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux: JR > J > branch > stall > PC+4, with
// word alignment of redirect targets and misalignment detection.
module next_pc_select
  import pipeline_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_stall_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_jump_reg,
  input  logic [31:0] i_jump_reg_target,
  output logic [31:0] o_next_pc,
  output npc_sel_e    o_sel,
  output logic        o_misaligned
);

  logic [31:0] w_raw_target;

  always_comb begin
    o_sel        = SEL_PC4;
    w_raw_target = i_branch_target;
    // Redirects beat Stall_PC: the redirecting instruction is older.
    if (i_jump_reg) begin
      o_sel        = SEL_JR;
      w_raw_target = i_jump_reg_target;
    end else if (i_jump) begin
      o_sel        = SEL_J;
      w_raw_target = i_jump_target;
    end else if (i_branch_taken) begin
      o_sel        = SEL_BR;
      w_raw_target = i_branch_target;
    end else if (i_stall_pc) begin
      o_sel        = SEL_HOLD;
    end
  end

  always_comb begin
    o_next_pc    = i_pc_plus4;
    o_misaligned = 1'b0;
    if (is_redirect(o_sel)) begin
      o_next_pc    = {w_raw_target[31:2], 2'b00};
      o_misaligned = |w_raw_target[1:0];
    end else if (o_sel == SEL_HOLD) begin
      o_next_pc    = i_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register,
// BOOT/RUN sequencing and saturating fetch/redirect counters.
module pc_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall_PC,
  input  logic             Stall_IFID,
  input  logic             Flush_IFID,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             JumpReg,
  input  logic [31:0]      JumpRegTarget,
  input  logic [31:0]      Instruction_In,
  output logic [31:0]      PC_Out,
  output logic [31:0]      IFID_Instruction,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic             Misaligned,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] RedirectCount
);

  fetch_state_e     r_state, w_state_nxt;
  logic             w_run;
  logic [31:0]      r_pc, w_pc_plus4, w_next_pc;
  npc_sel_e         w_sel;
  logic             w_misaligned, w_redirect;
  logic             w_ifid_load;
  logic [31:0]      r_ifid_instr, r_ifid_pcp4;
  logic             r_ifid_valid, r_misaligned;
  logic [CNT_W-1:0] r_fetch_cnt, r_redir_cnt;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_select u_npc (
    .i_pc              (r_pc),
    .i_pc_plus4        (w_pc_plus4),
    .i_stall_pc        (Stall_PC),
    .i_branch_taken    (BranchTaken),
    .i_branch_target   (BranchTarget),
    .i_jump            (Jump),
    .i_jump_target     (JumpTarget),
    .i_jump_reg        (JumpReg),
    .i_jump_reg_target (JumpRegTarget),
    .o_next_pc         (w_next_pc),
    .o_sel             (w_sel),
    .o_misaligned      (w_misaligned)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= ST_BOOT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_run       = 1'b1;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  assign w_redirect  = w_run && is_redirect(w_sel);
  assign w_ifid_load = w_run && !Flush_IFID && !Stall_IFID;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pcp4  <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (w_run) begin
      r_pc <= w_next_pc;
      if (w_redirect && w_misaligned) r_misaligned <= 1'b1;
      // Flush keeps PCPlus4 so a bubble still carries its origin.
      if (Flush_IFID) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else if (!Stall_IFID) begin
        r_ifid_instr <= Instruction_In;
        r_ifid_pcp4  <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_ifid_load && (r_fetch_cnt != {CNT_W{1'b1}}))
        r_fetch_cnt <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_redirect && (r_redir_cnt != {CNT_W{1'b1}}))
        r_redir_cnt <= r_redir_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign PC_Out           = r_pc;
  assign IFID_Instruction = r_ifid_instr;
  assign IFID_PCPlus4     = r_ifid_pcp4;
  assign IFID_Valid       = r_ifid_valid;
  assign Misaligned       = r_misaligned;
  assign FetchCount       = r_fetch_cnt;
  assign RedirectCount    = r_redir_cnt;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, random traffic against a
// behavioural model, async reset mid-run and counter saturation (CNT_W=4 copy).
module tb_pc_fetch_stage;

  localparam logic [31:0] PAT = 32'hDEAD_BEEF;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall_PC, Stall_IFID, Flush_IFID;
  logic        BranchTaken, Jump, JumpReg;
  logic [31:0] BranchTarget, JumpTarget, JumpRegTarget;
  logic [31:0] Instruction_In, PC_Out, IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid, Misaligned;
  logic [15:0] FetchCount, RedirectCount;
  logic [31:0] s_Instruction_In, s_PC_Out, s_IFID_Instruction, s_IFID_PCPlus4;
  logic        s_IFID_Valid, s_Misaligned;
  logic [3:0]  s_FetchCount, s_RedirectCount;

  always #5 Clk = ~Clk;

  // Combinational instruction memory: contents derived from the address.
  assign Instruction_In   = PC_Out ^ PAT;
  assign s_Instruction_In = s_PC_Out ^ PAT;

  pc_fetch_stage #(.CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID),
    .Flush_IFID(Flush_IFID), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
    .Instruction_In(Instruction_In), .PC_Out(PC_Out), .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .Misaligned(Misaligned),
    .FetchCount(FetchCount), .RedirectCount(RedirectCount)
  );

  pc_fetch_stage #(.CNT_W(4)) dut_small (
    .Clk(Clk), .Rst(Rst), .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID),
    .Flush_IFID(Flush_IFID), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
    .Instruction_In(s_Instruction_In), .PC_Out(s_PC_Out), .IFID_Instruction(s_IFID_Instruction),
    .IFID_PCPlus4(s_IFID_PCPlus4), .IFID_Valid(s_IFID_Valid), .Misaligned(s_Misaligned),
    .FetchCount(s_FetchCount), .RedirectCount(s_RedirectCount)
  );

  typedef struct {
    bit          spc, sif, fl;
    bit          br;  logic [31:0] bt;
    bit          j;   logic [31:0] jt;
    bit          jr;  logic [31:0] jrt;
    logic [31:0] e_pc, e_instr, e_p4;
    bit          e_v;
    int          e_f, e_r;
    bit          e_m;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_boot, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_p4;
  int          m_f, m_r;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0;
    m_valid = 0; m_mis = 0; m_f = 0; m_r = 0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt, nxt;
    bit          redir;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    redir = JumpReg || Jump || BranchTaken;
    tgt = JumpReg ? JumpRegTarget : Jump ? JumpTarget : BranchTarget;
    if (redir) begin
      nxt = tgt & 32'hFFFF_FFFC;
      m_r++;
      if (tgt % 4 != 0) m_mis = 1;
    end else if (Stall_PC) nxt = m_pc;
    else nxt = m_pc + 32'd4;
    if (Flush_IFID) begin
      m_instr = 32'h0; m_valid = 0;
    end else if (!Stall_IFID) begin
      m_instr = m_pc ^ PAT; m_p4 = m_pc + 32'd4; m_valid = 1; m_f++;
    end
    m_pc = nxt;
  endtask

  task automatic cmp_model();
    chk("pc",        PC_Out,                 m_pc);
    chk("instr",     IFID_Instruction,       m_instr);
    chk("pcplus4",   IFID_PCPlus4,           m_p4);
    chk("valid",     32'(IFID_Valid),        32'(m_valid));
    chk("misalign",  32'(Misaligned),        32'(m_mis));
    chk("fetchcnt",  32'(FetchCount),        32'(sat(m_f, 16)));
    chk("redircnt",  32'(RedirectCount),     32'(sat(m_r, 16)));
    chk("s_pc",      s_PC_Out,               m_pc);
    chk("s_fetch",   32'(s_FetchCount),      32'(sat(m_f, 4)));
    chk("s_redir",   32'(s_RedirectCount),   32'(sat(m_r, 4)));
  endtask

  task automatic drive(input bit spc, input bit sif, input bit fl,
                       input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt,
                       input bit jr, input logic [31:0] jrt);
    Stall_PC = spc; Stall_IFID = sif; Flush_IFID = fl;
    BranchTaken = br; BranchTarget = bt;
    Jump = j; JumpTarget = jt; JumpReg = jr; JumpRegTarget = jrt;
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b1,32'h100, 1'b0,32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0,0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h4, 32'hDEADBEEF, 32'h4, 1'b1, 1,0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h8, 32'hDEADBEEB, 32'h8, 1'b1, 2,0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'hC, 32'hDEADBEE7, 32'hC, 1'b1, 3,0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h10, 32'hDEADBEE3, 32'h10, 1'b1, 4,0,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h10, 32'hDEADBEE3, 32'h10, 1'b1, 4,0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h10, 32'hDEADBEE3, 32'h10, 1'b1, 4,0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h14, 32'hDEADBEFF, 32'h14, 1'b1, 5,0,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0, 1'b1,32'h80, 1'b1,32'h100, 1'b1,32'h200, 32'h200, 32'hDEADBEFB, 32'h18, 1'b1, 6,1,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h204, 32'h0, 32'h18, 1'b0, 6,1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1, 1'b1,32'h43, 1'b0,32'h0, 1'b0,32'h0, 32'h40, 32'h0, 32'h18, 1'b0, 6,2,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h44, 32'hDEADBEAF, 32'h44, 1'b1, 7,2,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b1,32'hFFFFFFFC, 1'b0,32'h0, 32'hFFFFFFFC, 32'hDEADBEAB, 32'h48, 1'b1, 8,3,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h0, 32'h21524113, 32'h0, 1'b1, 9,3,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 32'h4, 32'hDEADBEEF, 32'h4, 1'b1, 10,3,1'b1};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    Rst = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    cmp_model();
    chk("rst_pc", PC_Out, 32'h0);
    chk("rst_valid", 32'(IFID_Valid), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;

    // Directed table; row 0 is the BOOT edge and must ignore the jump.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].spc, tbl[i].sif, tbl[i].fl, tbl[i].br, tbl[i].bt,
            tbl[i].j, tbl[i].jt, tbl[i].jr, tbl[i].jrt);
      step();
      chk($sformatf("t%0d_pc", i),    PC_Out,           tbl[i].e_pc);
      chk($sformatf("t%0d_instr", i), IFID_Instruction, tbl[i].e_instr);
      chk($sformatf("t%0d_p4", i),    IFID_PCPlus4,     tbl[i].e_p4);
      chk($sformatf("t%0d_valid", i), 32'(IFID_Valid),  32'(tbl[i].e_v));
      chk($sformatf("t%0d_fetch", i), 32'(FetchCount),  32'(tbl[i].e_f));
      chk($sformatf("t%0d_redir", i), 32'(RedirectCount), 32'(tbl[i].e_r));
      chk($sformatf("t%0d_mis", i),   32'(Misaligned),  32'(tbl[i].e_m));
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom(),
            $urandom_range(0, 9) == 0, $urandom(),
            $urandom_range(0, 11) == 0, $urandom());
      step();
    end

    // Asynchronous reset between edges takes effect at once.
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    cmp_model();
    @(posedge Clk);
    #1;
    cmp_model();
    @(negedge Clk);
    Rst = 1'b1;

    // BOOT repeats, then 20 fetches: the 4-bit counter pins at 15.
    drive(0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
    step();
    chk("reboot_pc", PC_Out, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_small", 32'(s_FetchCount), 32'd15);
    chk("sat_big", 32'(FetchCount), 32'd20);
    chk("sat_pc", PC_Out, 32'd80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
